// File: rtl/receiver_integrate_dump.sv
// Integrate-and-dump symbol accumulator: sums sym_len signed products, then
// rounds, shifts and saturates the symbol sum into one output beat.
module receiver_integrate_dump #(
  parameter int IN_WIDTH  = 33,
  parameter int LEN_WIDTH = 10,
  parameter int ACC_WIDTH = 43,
  parameter int SHIFT     = 15,
  parameter int OUT_WIDTH = 18
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [LEN_WIDTH-1:0] sym_len,
  input  logic [IN_WIDTH-1:0]  prod_tdata,
  input  logic                 prod_tvalid,
  output logic                 prod_tready,
  output logic [OUT_WIDTH-1:0] out_tdata,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic                 out_sat
);

  localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_WIDTH-1:0] OMAX = (ACC_WIDTH'(1) <<< (OUT_WIDTH - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] OMIN = -(ACC_WIDTH'(1) <<< (OUT_WIDTH - 1));

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                      st, st_nxt;
  logic signed [IN_WIDTH-1:0]  prod_s;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum_p0;
  logic [LEN_WIDTH-1:0]        cnt;
  logic [LEN_WIDTH-1:0]        len_q;
  logic [LEN_WIDTH-1:0]        eff_len;
  logic                        accept;
  logic                        is_last;
  logic [OUT_WIDTH-1:0]        dout_p0;
  logic                        clip_p0;

  function automatic logic signed [ACC_WIDTH-1:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] x
  );
    logic signed [ACC_WIDTH-1:0] t;
    t = x + HALF;
    return t >>> SHIFT;
  endfunction

  // Result is {clip, value}.
  function automatic logic [OUT_WIDTH:0] saturate(
    input logic signed [ACC_WIDTH-1:0] x
  );
    if (x > OMAX) return {1'b1, OMAX[OUT_WIDTH-1:0]};
    if (x < OMIN) return {1'b1, OMIN[OUT_WIDTH-1:0]};
    return {1'b0, x[OUT_WIDTH-1:0]};
  endfunction

  assign out_tvalid  = (st == HOLD);
  assign prod_tready = !(out_tvalid && !out_tready);
  assign accept      = prod_tvalid && prod_tready;
  assign prod_s      = prod_tdata;

  // p0: symbol length selection, sum and dump value for the current sample
  always_comb begin
    eff_len = len_q;
    if (cnt == '0) begin
      eff_len = (sym_len == '0) ? LEN_WIDTH'(1) : sym_len;
    end
  end

  assign is_last = (cnt == eff_len - LEN_WIDTH'(1));
  assign sum_p0  = acc + ACC_WIDTH'(prod_s);
  assign {clip_p0, dout_p0} = saturate(round_shift(sum_p0));

  always_comb begin
    st_nxt = st;
    case (st)
      ACCUM: if (accept && is_last) st_nxt = HOLD;
      HOLD: begin
        if (accept && is_last) st_nxt = HOLD;
        else if (out_tready)   st_nxt = ACCUM;
      end
      default: st_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) st <= ACCUM;
    else           st <= st_nxt;
  end

  // p1: accumulator update and registered dump output
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      len_q     <= LEN_WIDTH'(1);
      out_tdata <= '0;
      out_sat   <= 1'b0;
    end else if (accept) begin
      if (cnt == '0) len_q <= eff_len;
      if (is_last) begin
        acc       <= '0;
        cnt       <= '0;
        out_tdata <= dout_p0;
        out_sat   <= clip_p0;
      end else begin
        acc <= sum_p0;
        cnt <= cnt + LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_receiver_integrate_dump.sv
// Bench for receiver_integrate_dump: directed scenarios plus randomized symbols
// compared against an arithmetic reference of the dump rule.
module tb_receiver_integrate_dump;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [9:0]  sym_len = '0;
  logic [32:0] prod_tdata = '0;
  logic        prod_tvalid = 1'b0;
  logic        prod_tready;
  logic [17:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_sat;

  logic [1:0]  rdy_mode = 2'd1;
  logic        rnd_rdy = 1'b1;
  int          checks = 0;
  int          failures = 0;
  logic [18:0] got[$];
  logic [18:0] exp_q[$];

  receiver_integrate_dump dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .sym_len    (sym_len),
    .prod_tdata (prod_tdata),
    .prod_tvalid(prod_tvalid),
    .prod_tready(prod_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_sat    (out_sat)
  );

  always #5 ap_clk = ~ap_clk;

  assign out_tready = (rdy_mode == 2'd2) ? rnd_rdy : rdy_mode[0];

  always @(posedge ap_clk) begin
    #1 rnd_rdy = 1'($urandom_range(0, 1));
  end

  always @(negedge ap_clk) begin
    if (ap_rst_n && out_tvalid && out_tready) got.push_back({out_sat, out_tdata});
  end

  // Reference dump: floor((sum + 2^14) / 2^15), clipped to 18-bit signed.
  function automatic logic [18:0] model_dump(input longint sum);
    longint num, r;
    num = sum + 64'sd16384;
    if (num >= 0) r = num / 32768;
    else          r = -((-num + 32767) / 32768);
    if (r > 131071)  return {1'b1, 18'h1FFFF};
    if (r < -131072) return {1'b1, 18'h20000};
    return {1'b0, r[17:0]};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic send(input logic signed [32:0] d);
    int n;
    n = 0;
    prod_tdata  = d;
    prod_tvalid = 1'b1;
    @(negedge ap_clk);
    while (!prod_tready && n < 200) begin
      n++;
      @(negedge ap_clk);
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout prod_tready stayed 0 (required 1)");
    end
    @(posedge ap_clk);
    #1 prod_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", out_tvalid); end
    checks++; if (out_tdata !== 18'd0) begin failures++; $display("FAIL rst_tdata got=%h exp=0", out_tdata); end
    checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL rst_sat got=%b exp=0", out_sat); end
    checks++; if (prod_tready !== 1'b1) begin failures++; $display("FAIL rst_tready got=%b exp=1", prod_tready); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_basic();
    int base, n_got;
    base = got.size();
    exp_q.delete();
    rdy_mode = 2'd1;
    sym_len  = 10'd4;
    repeat (3) send(33'sd32768);
    checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", out_tvalid); end
    send(33'sd32768);
    checks++; if (out_tvalid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", out_tvalid); end
    checks++; if (out_tdata !== 18'd4) begin failures++; $display("FAIL basic_data got=%0d exp=4", $signed(out_tdata)); end
    checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL basic_sat got=%b exp=0", out_sat); end
    exp_q.push_back(model_dump(4 * 32768));
    idle(3);
    n_got = got.size() - base;
    checks++; if (n_got != exp_q.size()) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", n_got, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
      checks++;
      if (got[base+i] !== exp_q[i]) begin failures++; $display("FAIL basic_out[%0d] got=%h exp=%h", i, got[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_rounding();
    int base, n_got;
    base = got.size();
    exp_q.delete();
    sym_len = 10'd1;
    send(33'sd16384);
    send(33'(-16385));
    send(33'(-16384));
    exp_q.push_back(model_dump(16384));
    exp_q.push_back(model_dump(-16385));
    exp_q.push_back(model_dump(-16384));
    idle(3);
    n_got = got.size() - base;
    checks++; if (n_got != exp_q.size()) begin failures++; $display("FAIL round_count got=%0d exp=%0d", n_got, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
      checks++;
      if (got[base+i] !== exp_q[i]) begin failures++; $display("FAIL round_out[%0d] got=%h exp=%h", i, got[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_saturation();
    int base, n_got;
    base = got.size();
    exp_q.delete();
    sym_len = 10'd1023;
    repeat (1023) send(33'h0FFFFFFFF);
    repeat (1023) send(33'h100000000);
    exp_q.push_back(model_dump(longint'(1023) * 64'sd4294967295));
    exp_q.push_back(model_dump(-(longint'(1023) * 64'sd4294967296)));
    idle(3);
    n_got = got.size() - base;
    checks++; if (n_got != exp_q.size()) begin failures++; $display("FAIL sat_count got=%0d exp=%0d", n_got, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
      checks++;
      if (got[base+i] !== exp_q[i]) begin failures++; $display("FAIL sat_out[%0d] got=%h exp=%h", i, got[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int base, n_got;
    logic signed [32:0] s[4];
    logic [17:0] hd;
    logic        hs;
    base = got.size();
    exp_q.delete();
    for (int i = 0; i < 4; i++) s[i] = 33'(int'($urandom_range(0, 2097152)) - 1048576);
    sym_len  = 10'd2;
    rdy_mode = 2'd0;
    send(s[0]);
    send(s[1]);
    hd = out_tdata;
    hs = out_sat;
    prod_tdata  = s[2];
    prod_tvalid = 1'b1;
    repeat (5) begin
      @(negedge ap_clk);
      checks++; if (prod_tready !== 1'b0) begin failures++; $display("FAIL bp_tready got=%b exp=0", prod_tready); end
      checks++; if (out_tvalid !== 1'b1) begin failures++; $display("FAIL bp_tvalid got=%b exp=1", out_tvalid); end
      checks++; if ({out_sat, out_tdata} !== {hs, hd}) begin failures++; $display("FAIL bp_hold got=%h exp=%h", {out_sat, out_tdata}, {hs, hd}); end
    end
    @(posedge ap_clk);
    #1 rdy_mode = 2'd1;
    @(negedge ap_clk);
    checks++; if (prod_tready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", prod_tready); end
    @(posedge ap_clk);
    #1 prod_tvalid = 1'b0;
    send(s[3]);
    exp_q.push_back(model_dump(longint'(s[0]) + longint'(s[1])));
    exp_q.push_back(model_dump(longint'(s[2]) + longint'(s[3])));
    idle(3);
    n_got = got.size() - base;
    checks++; if (n_got != exp_q.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", n_got, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
      checks++;
      if (got[base+i] !== exp_q[i]) begin failures++; $display("FAIL bp_out[%0d] got=%h exp=%h", i, got[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_len_change();
    int base, n_got;
    logic signed [32:0] s[9];
    base = got.size();
    exp_q.delete();
    for (int i = 0; i < 9; i++) s[i] = 33'(int'($urandom_range(0, 4194304)) - 2097152);
    sym_len = 10'd4;
    send(s[0]);
    send(s[1]);
    sym_len = 10'd2;
    send(s[2]);
    checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL len_early_dump got=%b exp=0", out_tvalid); end
    send(s[3]);
    send(s[4]);
    send(s[5]);
    exp_q.push_back(model_dump(longint'(s[0]) + longint'(s[1]) + longint'(s[2]) + longint'(s[3])));
    exp_q.push_back(model_dump(longint'(s[4]) + longint'(s[5])));
    sym_len = 10'd0;
    for (int i = 6; i < 9; i++) begin
      send(s[i]);
      exp_q.push_back(model_dump(longint'(s[i])));
    end
    idle(3);
    n_got = got.size() - base;
    checks++; if (n_got != exp_q.size()) begin failures++; $display("FAIL len_count got=%0d exp=%0d", n_got, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
      checks++;
      if (got[base+i] !== exp_q[i]) begin failures++; $display("FAIL len_out[%0d] got=%h exp=%h", i, got[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int base, n_got;
    base = got.size();
    exp_q.delete();
    // pending output in HOLD is dropped by reset
    rdy_mode = 2'd0;
    sym_len  = 10'd1;
    send(33'sd163840);
    checks++; if (out_tvalid !== 1'b1) begin failures++; $display("FAIL rmid_hold got=%b exp=1", out_tvalid); end
    #2 ap_rst_n = 1'b0;
    #1;
    checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL rmid_hold_tvalid got=%b exp=0", out_tvalid); end
    checks++; if (out_tdata !== 18'd0) begin failures++; $display("FAIL rmid_hold_tdata got=%h exp=0", out_tdata); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1 rdy_mode = 2'd1;
    checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL rmid_after_hold got=%b exp=0", out_tvalid); end
    // partial sum is dropped by reset
    sym_len = 10'd4;
    repeat (3) send(33'sd32768);
    #2 ap_rst_n = 1'b0;
    #1;
    checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL rmid_tvalid got=%b exp=0", out_tvalid); end
    checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL rmid_sat got=%b exp=0", out_sat); end
    checks++; if (prod_tready !== 1'b1) begin failures++; $display("FAIL rmid_tready got=%b exp=1", prod_tready); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    repeat (4) send(33'sd32768);
    exp_q.push_back(model_dump(4 * 32768));
    idle(3);
    n_got = got.size() - base;
    checks++; if (n_got != exp_q.size()) begin failures++; $display("FAIL rmid_count got=%0d exp=%0d", n_got, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
      checks++;
      if (got[base+i] !== exp_q[i]) begin failures++; $display("FAIL rmid_out[%0d] got=%h exp=%h", i, got[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int base, n_got, len, eff;
    longint sum;
    logic signed [32:0] v;
    base = got.size();
    exp_q.delete();
    rdy_mode = 2'd2;
    for (int sym = 0; sym < 40; sym++) begin
      len = $urandom_range(0, 5);
      sym_len = 10'(len);
      eff = (len == 0) ? 1 : len;
      sum = 0;
      for (int k = 0; k < eff; k++) begin
        if ($urandom_range(0, 1) == 1) v = 33'({$urandom(), $urandom()});
        else                           v = 33'(int'($urandom_range(0, 2097152)) - 1048576);
        send(v);
        sum += longint'(v);
        if (k == 0) sym_len = 10'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      exp_q.push_back(model_dump(sum));
    end
    rdy_mode = 2'd1;
    idle(5);
    n_got = got.size() - base;
    checks++; if (n_got != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", n_got, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
      checks++;
      if (got[base+i] !== exp_q[i]) begin failures++; $display("FAIL rand_out[%0d] got=%h exp=%h", i, got[base+i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_len_change();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
